pointwise_scheduler: RTL
========================

Name: pointwise_scheduler

Overview:
- Sequencer for the 8x8 pointwise (1x1 conv) compute array.
- Walks every output pixel (h,w), every 8-wide output-channel tile and every 8-wide input-channel tile.
- Drives tile selects, bias/accumulate flags and a latency-matched writeback strobe, so the datapath no longer derives its own loop state.
- Sits between the layer controller (start/config) and the pointwise datapath plus intermediate buffer.

Parameters:
- TILE, 8: channels per tile; selects step by TILE.
- LAT, 3: compute-engine latency in cycles from tile issue to result.
- DIM_W, 8: width of size, channel and select fields.

Ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- start  in  1  one-cycle pulse; latches config and begins a layer.
- output_size  in  DIM_W  feature height = width.
- input_channel  in  DIM_W  input channel count.
- output_channel  in  DIM_W  output channel count.
- tile_ready  in  1  datapath accepts the issued tile this cycle.
- tile_valid  out  1  current selects are a valid tile issue.
- out_h, out_w  out  DIM_W  pixel of the issued tile.
- ic_sel, oc_sel  out  DIM_W  base channel of the issued tile.
- first_ic  out  1  issued tile is ic_sel==0; datapath adds bias.
- last_ic  out  1  issued tile is the final ic tile; result completes.
- wb_valid  out  1  accumulated 8-channel result is ready to write.
- wb_h, wb_w, wb_oc  out  DIM_W  writeback address, aligned to wb_valid.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse after the last writeback.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, delay line cleared. Reset mid-layer aborts immediately; no done pulse.
- Config latched on start in IDLE. Derived values:
  - ic_last = ((input_channel-1)/TILE)*TILE
  - oc_last = ((output_channel-1)/TILE)*TILE
  - hw_last = output_size-1
- start while not IDLE: ignored.
- IDLE --start, config legal--> RUN. If output_size==0, input_channel==0 or output_channel==0: --> DONE directly, with no tile issued and no wb_valid.
- RUN: tile_valid=1.
  - On a tile_valid&&tile_ready handshake, advance in this order: ic_sel += TILE; at ic_last wrap to 0 and oc_sel += TILE; at oc_last wrap to 0 and out_w++; at hw_last wrap to 0 and out_h++.
  - No handshake: all selects hold.
  - Handshake on the final tile (h=w=hw_last, oc=oc_last, ic=ic_last) --> DRAIN, tile_valid=0 next cycle.
- first_ic and last_ic are combinational from ic_sel, valid only while tile_valid.
- Writeback pipeline: LAT-stage shift register loaded by {handshake&&last_ic, out_h, out_w, oc_sel}. wb_valid and wb_* are stage LAT, so wb_valid rises exactly LAT cycles after the accepting handshake edge.
- DRAIN: waits LAT cycles (counter) so every in-flight wb drains, then --> DONE.
- DONE: done=1 for one cycle, busy=0, --> IDLE. Selects return to 0.
- Channels <= TILE: single tile, so first_ic and last_ic are both 1 on every issue.
- Channel counts not a multiple of TILE: the last tile is partial; the datapath masks it. The scheduler still issues that base.
- Total handshakes per layer = size² · (oc_last/TILE+1) · (ic_last/TILE+1). wb_valid count = size² · (oc_last/TILE+1).
- Selects never exceed ic_last/oc_last. Arithmetic uses DIM_W+1 bits internally to avoid overflow at 255.

Decomposition:
- Shared package pw_pkg: TILE, LAT, DIM_W constants and state enum {IDLE, RUN, DRAIN, DONE}.
- One sub-module, pw_wb_delay: a parameterised LAT-deep valid+address shift register, reusable by the depthwise scheduler.

Test Plan:
- size=2, ic=16, oc=16, tile_ready=1 -> 16 handshakes. ic_sel sequence 0,8,0,8…; wb_valid 8 times, first at handshake 2 +LAT; done on cycle 16+LAT+1 after start; wb addresses (0,0,0),(0,0,8),(0,1,0)…
- size=1, ic=8, oc=24 -> 3 tiles, each with first_ic=last_ic=1, oc_sel 0,8,16; 3 wb_valid; done pulse once.
- tile_ready toggling 1,0,1,0 on the size=2/ic=16/oc=16 case -> selects hold on stall cycles; same 16 handshakes and identical wb address order; done delayed by the stall count.
- ic=20, oc=8, size=1 -> ic_sel 0,8,16 (ic_last=16); wb_valid once, after the ic=16 tile.
- output_channel=0 at start -> busy 1 cycle, done pulse, zero tile_valid and zero wb_valid.
- rst_n low for 1 cycle mid-RUN, then a new start -> all outputs 0 immediately; no stale wb_valid emerges; the new layer runs from (0,0,0,0).

Source files
------------

// File: rtl/pw_pkg.sv
// Shared constants, state encoding and tile arithmetic for the pointwise scheduler.
package pw_pkg;

   localparam int unsigned TILE  = 8;
   localparam int unsigned LAT   = 3;
   localparam int unsigned DIM_W = 8;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} pw_state_e;

   // Base channel of the final (possibly partial) tile for a non-zero count n.
   function automatic logic [DIM_W-1:0] last_base(input logic [DIM_W-1:0] n);
      logic [DIM_W-1:0] m;
      m = n - 1'b1;
      return (m / DIM_W'(TILE)) * DIM_W'(TILE);
   endfunction

endpackage

// File: rtl/pw_wb_delay.sv
// Depth-stage valid+address shift register that aligns writeback with engine latency.
module pw_wb_delay #(
   parameter int unsigned Depth = 3,
   parameter int unsigned Width = 24
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   input  logic [Width-1:0] i_data,
   output logic             o_valid,
   output logic [Width-1:0] o_data
);

   logic [Depth-1:0] r_valid;
   logic [Width-1:0] r_data [Depth];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid <= '0;
         for (int i = 0; i < Depth; i++) begin
            r_data[i] <= '0;
         end
      end else begin
         r_valid[0] <= i_valid;
         r_data[0]  <= i_data;
         for (int i = 1; i < Depth; i++) begin
            r_valid[i] <= r_valid[i-1];
            r_data[i]  <= r_data[i-1];
         end
      end
   end

   assign o_valid = r_valid[Depth-1];
   assign o_data  = r_data[Depth-1];

endmodule

// File: rtl/pointwise_scheduler.sv
// Loop sequencer for the 8x8 pointwise array: walks (h, w, oc tile, ic tile) and
// emits tile selects, bias/accumulate flags and a latency-aligned writeback strobe.
module pointwise_scheduler
   import pw_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [DIM_W-1:0] i_output_size,
   input  logic [DIM_W-1:0] i_input_channel,
   input  logic [DIM_W-1:0] i_output_channel,
   input  logic             i_tile_ready,
   output logic             o_tile_valid,
   output logic [DIM_W-1:0] o_out_h,
   output logic [DIM_W-1:0] o_out_w,
   output logic [DIM_W-1:0] o_ic_sel,
   output logic [DIM_W-1:0] o_oc_sel,
   output logic             o_first_ic,
   output logic             o_last_ic,
   output logic             o_wb_valid,
   output logic [DIM_W-1:0] o_wb_h,
   output logic [DIM_W-1:0] o_wb_w,
   output logic [DIM_W-1:0] o_wb_oc,
   output logic             o_busy,
   output logic             o_done
);

   localparam int unsigned  CNT_W  = $clog2(LAT + 1);
   localparam logic [DIM_W:0] TILE_X = (DIM_W + 1)'(TILE);

   pw_state_e        r_state;
   logic [DIM_W-1:0] r_ic_last, r_oc_last, r_hw_last;
   logic [DIM_W-1:0] r_out_h, r_out_w, r_ic_sel, r_oc_sel;
   logic             r_tile_valid, r_busy, r_done;
   logic [CNT_W-1:0] r_cnt;

   logic             w_hs, w_cfg_empty, w_final;
   logic             w_ic_wrap, w_oc_wrap, w_w_wrap, w_h_wrap;
   logic [DIM_W:0]   w_ic_next, w_oc_next, w_w_next;
   logic [3*DIM_W-1:0] w_wb_data;

   assign w_hs        = r_tile_valid & i_tile_ready;
   assign w_cfg_empty = (i_output_size == '0) | (i_input_channel == '0) |
                        (i_output_channel == '0);

   // One extra bit so stepping past the last base is visible instead of wrapping at 256.
   assign w_ic_next = {1'b0, r_ic_sel} + TILE_X;
   assign w_oc_next = {1'b0, r_oc_sel} + TILE_X;
   assign w_w_next  = {1'b0, r_out_w} + 1'b1;
   assign w_ic_wrap = w_ic_next > {1'b0, r_ic_last};
   assign w_oc_wrap = w_oc_next > {1'b0, r_oc_last};
   assign w_w_wrap  = w_w_next > {1'b0, r_hw_last};
   assign w_h_wrap  = r_out_h == r_hw_last;
   assign w_final   = w_ic_wrap & w_oc_wrap & w_w_wrap & w_h_wrap;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= IDLE;
         r_ic_last    <= '0;
         r_oc_last    <= '0;
         r_hw_last    <= '0;
         r_out_h      <= '0;
         r_out_w      <= '0;
         r_ic_sel     <= '0;
         r_oc_sel     <= '0;
         r_tile_valid <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_cnt        <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (i_start) begin
                  r_ic_last <= last_base(i_input_channel);
                  r_oc_last <= last_base(i_output_channel);
                  r_hw_last <= i_output_size - 1'b1;
                  r_busy    <= 1'b1;
                  // An empty layer still shows one busy cycle before its done pulse.
                  if (w_cfg_empty) begin
                     r_state <= DRAIN;
                     r_cnt   <= CNT_W'(LAT - 1);
                  end else begin
                     r_state      <= RUN;
                     r_tile_valid <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (w_hs) begin
                  if (w_final) begin
                     r_state      <= DRAIN;
                     r_tile_valid <= 1'b0;
                     r_cnt        <= '0;
                     r_out_h      <= '0;
                     r_out_w      <= '0;
                     r_ic_sel     <= '0;
                     r_oc_sel     <= '0;
                  end else if (!w_ic_wrap) begin
                     r_ic_sel <= w_ic_next[DIM_W-1:0];
                  end else begin
                     r_ic_sel <= '0;
                     if (!w_oc_wrap) begin
                        r_oc_sel <= w_oc_next[DIM_W-1:0];
                     end else begin
                        r_oc_sel <= '0;
                        if (!w_w_wrap) begin
                           r_out_w <= w_w_next[DIM_W-1:0];
                        end else begin
                           r_out_w <= '0;
                           r_out_h <= r_out_h + 1'b1;
                        end
                     end
                  end
               end
            end
            DRAIN: begin
               if (r_cnt == CNT_W'(LAT - 1)) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DONE: begin
               r_state  <= IDLE;
               r_done   <= 1'b0;
               r_out_h  <= '0;
               r_out_w  <= '0;
               r_ic_sel <= '0;
               r_oc_sel <= '0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign w_wb_data = {r_out_h, r_out_w, r_oc_sel};

   pw_wb_delay #(
      .Depth (LAT),
      .Width (3 * DIM_W)
   ) u_wb_delay (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_valid (w_hs & o_last_ic),
      .i_data  (w_wb_data),
      .o_valid (o_wb_valid),
      .o_data  ({o_wb_h, o_wb_w, o_wb_oc})
   );

   assign o_tile_valid = r_tile_valid;
   assign o_out_h      = r_out_h;
   assign o_out_w      = r_out_w;
   assign o_ic_sel     = r_ic_sel;
   assign o_oc_sel     = r_oc_sel;
   assign o_first_ic   = r_tile_valid & (r_ic_sel == '0);
   assign o_last_ic    = r_tile_valid & (r_ic_sel == r_ic_last);
   assign o_busy       = r_busy;
   assign o_done       = r_done;

endmodule
